inst_mem_pipelined: RTL and testbench
=====================================

// Module: inst_mem_pipelined
// PURPOSE
//   Parametrised instruction memory for the ARM fetch stage. Byte-addressed storage
//   holds the program; a write port loads it, replacing any hard-coded image.
//   Reads are pipelined with a configurable latency and use a valid/ready handshake
//   with stall. Misaligned and out-of-range fetches are flagged as faults.
// PARAMETERS
//   ADDR_W      32  byte-address width
//   DATA_W      32  instruction width; must be a multiple of 8
//   DEPTH_WORDS 64  number of instruction words stored
//   READ_LAT    1   cycles from accepted request to rsp_valid; legal range 1..4
//   BIG_ENDIAN  1   1: byte at the lowest address is the instruction MSB; 0: it is the LSB
// PORTS
//   clk        in   1       clock; all logic is on the rising edge
//   rst        in   1       synchronous, active-high reset
//   req_valid  in   1       fetch request
//   req_addr   in   ADDR_W  fetch byte address
//   req_ready  out  1       equals !stall && !rst; request accepted when req_valid && req_ready
//   stall      in   1       freeze the read pipeline and hold all rsp_* outputs
//   rsp_valid  out  1       response valid
//   rsp_instr  out  DATA_W  fetched instruction; 0 when rsp_fault is 1
//   rsp_addr   out  ADDR_W  address of the response
//   rsp_fault  out  1       misaligned or out-of-range fetch
//   prog_we    in   1       program-load write enable
//   prog_addr  in   ADDR_W  program-load byte address (word aligned)
//   prog_data  in   DATA_W  program-load word
// BEHAVIOUR
//   - Reset: rsp_valid, rsp_instr, rsp_addr, rsp_fault and all stage-valid bits go to 0
//     on the first clk edge with rst=1. Memory contents are not cleared. In-flight
//     requests are dropped. Requests and writes presented while rst=1 are ignored.
//   - Word index = req_addr >> log2(DATA_W/8).
//   - Fault when the low address bits are non-zero, or when index >= DEPTH_WORDS.
//     A faulting request still flows through the pipeline and produces a response,
//     with rsp_fault=1 and rsp_instr=0. There is no wrap-around.
//   - Latency: a request accepted at edge N, with no stall, gives rsp_valid=1 after
//     edge N+READ_LAT-1. rsp_valid is a one-cycle pulse per request.
//   - Throughput: one request per cycle. Back-to-back requests return in order.
//   - Stall: while stall=1, no stage advances and all rsp_* outputs hold their values.
//     Requests are not accepted, because req_ready=0.
//   - Write: when prog_we=1 and prog_addr is aligned and in range, the word is written
//     at the clk edge. Misaligned or out-of-range writes are silently dropped.
//     Writes proceed during stall.
//   - Read and write to the same word in the same cycle: the read returns the OLD data
//     (read-before-write). A request accepted one cycle later sees the new data.
//   - Byte assembly: with BIG_ENDIAN=1, {mem[a], mem[a+1], ...}; with BIG_ENDIAN=0 the
//     byte order is reversed.
// STRUCTURE
//   - Package inst_mem_pkg holds: BYTES_PER_WORD, the derived offset width, the
//     READ_LAT legality check, and the instruction reset/NOP constant (all zeros).
//   - Sub-module inst_mem_pipe_stage: one register stage with fields valid, addr,
//     instr and fault, a hold input (stall) and synchronous reset. It is instantiated
//     READ_LAT-1 times after the array read stage.
// TESTING
//   1. Reset and idle: rst=1 for 2 cycles -> rsp_valid=0, rsp_instr=0, req_ready=0;
//      after release req_ready=1.
//   2. Load and read: write 0x00221000 at 0 and 0x00432000 at 4, then fetch 0 and 4
//      back to back with READ_LAT=2 -> two rsp_valid pulses in order, on consecutive
//      cycles, with those data.
//   3. Faults: fetch 0x2 -> rsp_fault=1, rsp_instr=0. Fetch 4*DEPTH_WORDS ->
//      rsp_fault=1. A write to 0x3 leaves the memory unchanged.
//   4. Stall: accept a fetch of address 8, then assert stall for 3 cycles ->
//      outputs frozen and req_ready=0. After release the response appears exactly
//      once, with no duplicate and no loss.
//   5. Read-before-write: fetch 12 and write 0xDEADBEEF to 12 in the same cycle ->
//      the old value is returned. Re-fetch -> 0xDEADBEEF.
//   6. Reset mid-flight: accept fetches of 0 and 4, assert rst before they complete ->
//      no rsp_valid, and the memory still returns the loaded data afterwards.

Source files
------------

// File: rtl/inst_mem_pipelined_pkg.sv
// Shared geometry helpers, parameter legality checks and constants for the
// pipelined instruction memory.
package inst_mem_pkg;

    localparam int BYTE_W       = 8;
    localparam int MIN_READ_LAT = 1;
    localparam int MAX_READ_LAT = 4;
    localparam int MAX_DATA_W   = 128;

    // Geometry of the default 32-bit instruction word
    localparam int BYTES_PER_WORD = 4;
    localparam int OFFSET_W       = 2;

    localparam logic [MAX_DATA_W-1:0] INSTR_NOP = '0;

    function automatic int bytes_per_word(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int offset_w(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat >= MIN_READ_LAT) && (lat <= MAX_READ_LAT);
    endfunction

    // Word size must be whole bytes and a power-of-two byte count so the
    // word index is a plain shift of the byte address.
    function automatic bit data_w_ok(input int data_w);
        int bpw;
        bpw = data_w / BYTE_W;
        return (data_w % BYTE_W == 0) && (bpw >= 1) && (data_w <= MAX_DATA_W)
               && ((bpw & (bpw - 1)) == 0);
    endfunction

endpackage

// File: rtl/inst_mem_pipelined_if.sv
// Fetch-side bus of the instruction memory: request handshake, stall and
// response fields.
interface inst_mem_pipelined_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_fault;

    modport master (
        output req_valid, req_addr, stall,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, stall,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

endinterface

// File: rtl/inst_mem_pipelined_pipe_stage.sv
// One response-pipeline register stage (valid, addr, instr, fault) that
// freezes while held and clears on synchronous reset.
module inst_mem_pipe_stage
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_instr,
    input  logic              i_fault,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_fault
);

    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_instr;
    logic              r_fault;

    // Payload only moves with a valid token, so bubbles leave the last
    // response visible on the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_addr  <= '0;
            r_instr <= INSTR_NOP[DATA_W-1:0];
            r_fault <= 1'b0;
        end else if (!i_hold) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_addr  <= i_addr;
                r_instr <= i_instr;
                r_fault <= i_fault;
            end
        end
    end

    assign o_vld   = r_vld;
    assign o_addr  = r_addr;
    assign o_instr = r_instr;
    assign o_fault = r_fault;

endmodule

// File: rtl/inst_mem_pipelined.sv
// Byte-addressed instruction memory with a program-load write port and a
// pipelined, stallable fetch port that flags misaligned/out-of-range fetches.
module inst_mem_pipelined
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int READ_LAT    = 1,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_pipelined_if.slave  fetch,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [DATA_W-1:0]    prog_data
);

    localparam int BPW       = bytes_per_word(DATA_W);
    localparam int OFF_W     = offset_w(DATA_W);
    localparam int MEM_BYTES = DEPTH_WORDS * BPW;
    localparam int BA_W      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    generate
        if (!read_lat_ok(READ_LAT) || !data_w_ok(DATA_W)) begin : g_bad_param
            $error("inst_mem_pipelined: illegal READ_LAT or DATA_W");
        end
    endgenerate

    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        idx = a >> OFF_W;
        return ((a & ADDR_W'(BPW - 1)) != '0) || (idx >= ADDR_W'(DEPTH_WORDS));
    endfunction

    logic [7:0] r_mem [MEM_BYTES];

    logic              w_accept;
    logic              w_wr_ok;
    logic              w_rd_fault;
    logic [BA_W-1:0]   w_rd_ba;
    logic [BA_W-1:0]   w_wr_ba;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_instr;

    assign fetch.req_ready = !fetch.stall && !rst;
    assign w_accept        = fetch.req_valid && fetch.req_ready;
    assign w_rd_fault      = addr_fault(fetch.req_addr);
    assign w_rd_ba         = fetch.req_addr[BA_W-1:0];
    assign w_wr_ba         = prog_addr[BA_W-1:0];
    assign w_wr_ok         = prog_we && !rst && !addr_fault(prog_addr);

    // Program load; independent of stall, dropped when misaligned/out of range
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int k = 0; k < BPW; k++) begin
                if (BIG_ENDIAN != 0)
                    r_mem[w_wr_ba + BA_W'(k)] <= prog_data[DATA_W-1-8*k -: 8];
                else
                    r_mem[w_wr_ba + BA_W'(k)] <= prog_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < BPW; k++) begin
            if (BIG_ENDIAN != 0)
                w_rd_word[DATA_W-1-8*k -: 8] = r_mem[w_rd_ba + BA_W'(k)];
            else
                w_rd_word[8*k +: 8] = r_mem[w_rd_ba + BA_W'(k)];
        end
    end

    assign w_rd_instr = w_rd_fault ? INSTR_NOP[DATA_W-1:0] : w_rd_word;

    // ---- p0: array read stage (registers the old word on a same-cycle write)
    logic              r_vld_p0;
    logic [ADDR_W-1:0] r_addr_p0;
    logic [DATA_W-1:0] r_instr_p0;
    logic              r_fault_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0   <= 1'b0;
            r_addr_p0  <= '0;
            r_instr_p0 <= INSTR_NOP[DATA_W-1:0];
            r_fault_p0 <= 1'b0;
        end else if (!fetch.stall) begin
            r_vld_p0 <= w_accept;
            if (w_accept) begin
                r_addr_p0  <= fetch.req_addr;
                r_instr_p0 <= w_rd_instr;
                r_fault_p0 <= w_rd_fault;
            end
        end
    end

    logic              w_vld   [READ_LAT];
    logic [ADDR_W-1:0] w_addr  [READ_LAT];
    logic [DATA_W-1:0] w_instr [READ_LAT];
    logic              w_fault [READ_LAT];

    assign w_vld[0]   = r_vld_p0;
    assign w_addr[0]  = r_addr_p0;
    assign w_instr[0] = r_instr_p0;
    assign w_fault[0] = r_fault_p0;

    // ---- p1..pN: delay stages that stretch the latency to READ_LAT
    generate
        for (genvar g = 1; g < READ_LAT; g++) begin : g_stage
            inst_mem_pipe_stage #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_hold  (fetch.stall),
                .i_vld   (w_vld[g-1]),
                .i_addr  (w_addr[g-1]),
                .i_instr (w_instr[g-1]),
                .i_fault (w_fault[g-1]),
                .o_vld   (w_vld[g]),
                .o_addr  (w_addr[g]),
                .o_instr (w_instr[g]),
                .o_fault (w_fault[g])
            );
        end
    endgenerate

    assign fetch.rsp_valid = w_vld[READ_LAT-1];
    assign fetch.rsp_addr  = w_addr[READ_LAT-1];
    assign fetch.rsp_instr = w_instr[READ_LAT-1];
    assign fetch.rsp_fault = w_fault[READ_LAT-1];

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Directed bench for inst_mem_pipelined (READ_LAT=2) with an in-flight
// request model and literal checks on the collected responses.
module tb_inst_mem_pipelined;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;

    inst_mem_pipelined_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_mem_pipelined #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .READ_LAT    (LAT),
        .BIG_ENDIAN  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (bus),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          age;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          cyc;
    } rsp_t;

    logic [31:0] mdl_mem [DEPTH];
    ent_t        flight[$];
    rsp_t        got_q[$];
    logic        m_valid = 1'b0, m_fault = 1'b0, m_known = 1'b0, m_seen_rst = 1'b0;
    logic [31:0] m_instr = '0, m_addr = '0;
    logic        m_hold_edge = 1'b0;
    int          cyc = 0;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    always @(posedge clk) begin
        ent_t e;
        cyc++;
        m_hold_edge = rst || bus.stall;
        if (rst) begin
            flight.delete();
            m_valid = 1'b0; m_instr = '0; m_addr = '0; m_fault = 1'b0;
            m_known = 1'b1; m_seen_rst = 1'b1;
        end else begin
            if (!bus.stall) begin
                foreach (flight[i]) flight[i].age++;
                while (flight.size() > 0 && flight[0].age > LAT) void'(flight.pop_front());
                if (bus.req_valid) begin
                    e.addr  = bus.req_addr;
                    e.fault = bad_addr(bus.req_addr);
                    e.instr = e.fault ? 32'h0 : mdl_mem[bus.req_addr / 4];
                    e.age   = 1;
                    flight.push_back(e);
                end
                if (flight.size() > 0 && flight[0].age == LAT) begin
                    m_valid = 1'b1; m_known = 1'b1;
                    m_addr = flight[0].addr; m_instr = flight[0].instr; m_fault = flight[0].fault;
                end else begin
                    m_valid = 1'b0; m_known = 1'b0;
                end
            end
            if (prog_we && !bad_addr(prog_addr)) mdl_mem[prog_addr / 4] = prog_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        rsp_t r;
        #1;
        if (m_seen_rst) begin
            chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_valid});
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !bus.stall && !rst});
            if (m_valid || m_known) begin
                chk("rsp_addr",  bus.rsp_addr, m_addr);
                chk("rsp_instr", bus.rsp_instr, m_instr);
                chk("rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, m_fault});
            end
            if (bus.rsp_valid && !m_hold_edge) begin
                r.addr = bus.rsp_addr; r.instr = bus.rsp_instr;
                r.fault = bus.rsp_fault; r.cyc = cyc;
                got_q.push_back(r);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.req_valid = 1'b1; bus.req_addr = a;
        tick();
        bus.req_valid = 1'b0;
    endtask

    function automatic rsp_t got(input int i);
        rsp_t r;
        r.addr = '1; r.instr = 32'hxxxx_xxxx; r.fault = 1'bx; r.cyc = -100;
        if (i < got_q.size()) r = got_q[i];
        return r;
    endfunction

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.stall     = 1'b0;

        // 1: reset and idle
        idle(2);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_instr", bus.rsp_instr, 32'd0);
        chk("rst_rsp_addr",  bus.rsp_addr, 32'd0);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
        tick();

        // 2: load and back-to-back read
        wr(32'h0, 32'h0022_1000);
        wr(32'h4, 32'h0043_2000);
        got_q.delete();
        rd(32'h0);
        rd(32'h4);
        idle(5);
        chk("t2_count",  got_q.size(), 32'd2);
        chk("t2_instr0", got(0).instr, 32'h0022_1000);
        chk("t2_addr0",  got(0).addr,  32'h0);
        chk("t2_instr1", got(1).instr, 32'h0043_2000);
        chk("t2_addr1",  got(1).addr,  32'h4);
        chk("t2_consec", got(1).cyc - got(0).cyc, 32'd1);

        // 3: faults and dropped misaligned write
        wr(32'h3, 32'hFFFF_FFFF);
        got_q.delete();
        rd(32'h2);
        rd(32'(4 * DEPTH));
        rd(32'h0);
        idle(5);
        chk("t3_count",   got_q.size(), 32'd3);
        chk("t3_fault0",  {31'b0, got(0).fault}, 32'd1);
        chk("t3_instr0",  got(0).instr, 32'h0);
        chk("t3_fault1",  {31'b0, got(1).fault}, 32'd1);
        chk("t3_instr1",  got(1).instr, 32'h0);
        chk("t3_word0",   got(2).instr, 32'h0022_1000);
        chk("t3_fault2",  {31'b0, got(2).fault}, 32'd0);

        // 4a: stall while request is inside the pipeline
        wr(32'h8, 32'h1111_2222);
        got_q.delete();
        rd(32'h8);
        bus.stall = 1'b1;
        #1;
        chk("t4_ready_stall", {31'b0, bus.req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_frozen_valid", {31'b0, bus.rsp_valid}, 32'd0);
        end
        bus.stall = 1'b0;
        tick();
        chk("t4_rsp_after", {31'b0, bus.rsp_valid}, 32'd1);
        idle(4);
        chk("t4_count", got_q.size(), 32'd1);
        chk("t4_instr", got(0).instr, 32'h1111_2222);

        // 4b: stall while the response is on the outputs
        got_q.delete();
        rd(32'h8);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("t4_hold_instr", bus.rsp_instr, 32'h1111_2222);
        end
        bus.stall = 1'b0;
        tick();
        chk("t4_pulse_end", {31'b0, bus.rsp_valid}, 32'd0);
        idle(3);
        chk("t4b_count", got_q.size(), 32'd1);

        // 5: read-before-write on the same word
        wr(32'hC, 32'h1234_5678);
        got_q.delete();
        prog_we = 1'b1; prog_addr = 32'hC; prog_data = 32'hDEAD_BEEF;
        bus.req_valid = 1'b1; bus.req_addr = 32'hC;
        tick();
        prog_we = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        idle(4);
        chk("t5_count", got_q.size(), 32'd2);
        chk("t5_old",   got(0).instr, 32'h1234_5678);
        chk("t5_new",   got(1).instr, 32'hDEAD_BEEF);

        // 6: reset with requests in flight; write during reset is ignored
        got_q.delete();
        rd(32'h0);
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = 32'h4;
        prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'hBAD0_BAD0;
        tick();
        bus.req_valid = 1'b0; prog_we = 1'b0;
        tick();
        rst = 1'b0;
        idle(5);
        chk("t6_dropped", got_q.size(), 32'd0);
        rd(32'h0);
        rd(32'h4);
        idle(5);
        chk("t6_count",  got_q.size(), 32'd2);
        chk("t6_instr0", got(0).instr, 32'h0022_1000);
        chk("t6_instr1", got(1).instr, 32'h0043_2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
